// File: rtl/regfile_bank_multiport_if.sv
// Core-side bus of the multiport register file: one write port plus
// READ_PORTS flattened read ports and the clear-sweep busy flag.
interface regfile_bank_multiport_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5,
   parameter int READ_PORTS = 2
);
   logic                             writeEnable;
   logic [ADDR_WIDTH-1:0]            writeAddress;
   logic [DATA_WIDTH-1:0]            writeData;
   logic [READ_PORTS-1:0]            readEnable;
   logic [READ_PORTS*ADDR_WIDTH-1:0] readAddress;
   logic [READ_PORTS*DATA_WIDTH-1:0] readData;
   logic                             initBusy;

   modport master (
      output writeEnable, writeAddress, writeData, readEnable, readAddress,
      input  readData, initBusy
   );

   modport slave (
      input  writeEnable, writeAddress, writeData, readEnable, readAddress,
      output readData, initBusy
   );
endinterface

// File: rtl/regfile_bank_multiport.sv
// Register file with one write port, READ_PORTS registered read ports,
// write-to-read forwarding, optional zero register and a post-reset clear sweep.
module regfile_bank_multiport #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5,
   parameter int READ_PORTS = 2,
   parameter bit ZERO_REG   = 1'b1,
   parameter bit BYPASS     = 1'b1
) (
   input logic                     clk,
   input logic                     resetN,
   regfile_bank_multiport_if.slave bus
);
   localparam int DEPTH = 2 ** ADDR_WIDTH;
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

   typedef enum logic {INIT, RUN} state_t;

   state_t                state;
   logic [ADDR_WIDTH-1:0] sweep_cnt;
   logic                  init_busy_q;

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [DATA_WIDTH-1:0] rd_q [READ_PORTS];
   logic [ADDR_WIDTH-1:0] rd_addr [READ_PORTS];

   logic                  wr_accept;
   logic                  mem_we;
   logic [ADDR_WIDTH-1:0] mem_waddr;
   logic [DATA_WIDTH-1:0] mem_wdata;

   for (genvar p = 0; p < READ_PORTS; p++) begin : g_port_io
      assign rd_addr[p] = bus.readAddress[p*ADDR_WIDTH +: ADDR_WIDTH];
      assign bus.readData[p*DATA_WIDTH +: DATA_WIDTH] = rd_q[p];
   end

   assign bus.initBusy = init_busy_q;

   // A write to register 0 is discarded when it is hardwired to zero.
   assign wr_accept = bus.writeEnable && !(ZERO_REG && (bus.writeAddress == '0));

   // NOTE: every signal driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      mem_we    = 1'b0;
      mem_waddr = bus.writeAddress;
      mem_wdata = bus.writeData;
      if (state == INIT) begin
         mem_we    = 1'b1;
         mem_waddr = sweep_cnt;
         mem_wdata = '0;
      end else begin
         mem_we = wr_accept;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state       <= INIT;
         sweep_cnt   <= '0;
         init_busy_q <= 1'b1;
      end else begin
         case (state)
            INIT: begin
               sweep_cnt <= sweep_cnt + 1'b1;
               if (sweep_cnt == LAST_ADDR) begin
                  state       <= RUN;
                  init_busy_q <= 1'b0;
               end
            end
            RUN: begin
               init_busy_q <= 1'b0;
            end
            default: begin
               state       <= INIT;
               sweep_cnt   <= '0;
               init_busy_q <= 1'b1;
            end
         endcase
      end
   end

   // NOTE: the array has no reset so it maps to RAM; the clear sweep zeroes it instead.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[mem_waddr] <= mem_wdata;
      end
   end

   // Zero-register reads win over forwarding; disabled ports hold for stalls.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         for (int p = 0; p < READ_PORTS; p++) begin
            rd_q[p] <= '0;
         end
      end else begin
         for (int p = 0; p < READ_PORTS; p++) begin
            if (bus.readEnable[p]) begin
               if (state == INIT) begin
                  rd_q[p] <= '0;
               end else if (ZERO_REG && (rd_addr[p] == '0)) begin
                  rd_q[p] <= '0;
               end else if (BYPASS && bus.writeEnable && (bus.writeAddress == rd_addr[p])) begin
                  rd_q[p] <= bus.writeData;
               end else begin
                  rd_q[p] <= mem[rd_addr[p]];
               end
            end
         end
      end
   end
endmodule

// File: tb/tb_regfile_bank_multiport.sv
// Randomised and directed bench for regfile_bank_multiport, checked every
// cycle against a behavioural register-file model.
module tb_regfile_bank_multiport;
   localparam int DW    = 32;
   localparam int AW    = 5;
   localparam int RP    = 2;
   localparam bit ZR    = 1'b1;
   localparam bit BP    = 1'b1;
   localparam int DEPTH = 2 ** AW;

   logic clk    = 1'b0;
   logic resetN = 1'b1;

   regfile_bank_multiport_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_PORTS(RP)) bus ();

   regfile_bank_multiport #(
      .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_PORTS(RP), .ZERO_REG(ZR), .BYPASS(BP)
   ) dut (
      .clk(clk),
      .resetN(resetN),
      .bus(bus)
   );

   always #5 clk = ~clk;

   int vectors     = 0;
   int miscompares = 0;
   bit armed       = 1'b0;

   // Behavioural model: the sweep is just "DEPTH edges of busy after release",
   // after which every register reads as zero until written.
   logic [DW-1:0] m_mem [DEPTH];
   logic [DW-1:0] m_exp [RP];
   int            sweep_left;

   function automatic logic [AW-1:0] ra_of(input int p);
      return bus.readAddress[p*AW +: AW];
   endfunction

   function automatic logic [DW-1:0] rd_of(input int p);
      return bus.readData[p*DW +: DW];
   endfunction

   always @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         sweep_left <= DEPTH;
         for (int p = 0; p < RP; p++) m_exp[p] <= '0;
         for (int a = 0; a < DEPTH; a++) m_mem[a] <= '0;
      end else if (sweep_left > 0) begin
         sweep_left <= sweep_left - 1;
         for (int p = 0; p < RP; p++) if (bus.readEnable[p]) m_exp[p] <= '0;
      end else begin
         for (int p = 0; p < RP; p++) begin
            if (bus.readEnable[p]) begin
               if (ZR && ra_of(p) == 0)
                  m_exp[p] <= '0;
               else if (BP && bus.writeEnable && bus.writeAddress == ra_of(p))
                  m_exp[p] <= bus.writeData;
               else
                  m_exp[p] <= m_mem[ra_of(p)];
            end
         end
         if (bus.writeEnable && !(ZR && bus.writeAddress == 0))
            m_mem[bus.writeAddress] <= bus.writeData;
      end
   end

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (armed) begin
         check("init_busy", DW'(bus.initBusy), DW'(sweep_left != 0));
         for (int p = 0; p < RP; p++)
            check($sformatf("model_rdata%0d", p), rd_of(p), m_exp[p]);
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic set_ra(input int p, input logic [AW-1:0] a);
      bus.readAddress[p*AW +: AW] = a;
   endtask

   task automatic wait_sweep(input string name);
      int n = 0;
      while (bus.initBusy === 1'b1 && n < 100) begin
         tick();
         n++;
      end
      check(name, DW'(n), DW'(DEPTH));
   endtask

   initial begin
      bus.writeEnable  = 1'b0;
      bus.writeAddress = '0;
      bus.writeData    = '0;
      bus.readEnable   = '1;
      bus.readAddress  = '0;

      // Reset and full sweep
      #1 resetN = 1'b0;
      armed = 1'b1;
      repeat (3) tick();
      check("reset_busy", DW'(bus.initBusy), DW'(1));
      check("reset_rdata0", rd_of(0), '0);
      resetN = 1'b1;
      wait_sweep("sweep_len");

      for (int a = 0; a < DEPTH; a++) begin
         set_ra(a % RP, AW'(a));
         tick();
         check($sformatf("clear_r%0d", a), rd_of(a % RP), '0);
      end

      // Basic write then read on both ports
      bus.writeEnable = 1'b1; bus.writeAddress = 5; bus.writeData = 32'hDEADBEEF;
      tick();
      bus.writeEnable = 1'b0;
      set_ra(0, 5); set_ra(1, 5);
      tick();
      check("basic_p0", rd_of(0), 32'hDEADBEEF);
      check("basic_p1", rd_of(1), 32'hDEADBEEF);

      // Forwarding
      bus.writeEnable = 1'b1; bus.writeAddress = 7; bus.writeData = 32'h11111111;
      tick();
      bus.writeData = 32'h22222222; set_ra(0, 7); set_ra(1, 7);
      tick();
      check("fwd_same_edge", rd_of(0), BP ? 32'h22222222 : 32'h11111111);
      check("fwd_ports_agree", rd_of(1), BP ? 32'h22222222 : 32'h11111111);
      bus.writeEnable = 1'b0;
      tick();
      check("fwd_next_edge", rd_of(0), 32'h22222222);

      // Zero register
      bus.writeEnable = 1'b1; bus.writeAddress = 0; bus.writeData = 32'hFFFFFFFF; set_ra(0, 0);
      tick();
      check("zero_same_edge", rd_of(0), ZR ? 32'h0 : (BP ? 32'hFFFFFFFF : 32'h0));
      bus.writeEnable = 1'b0;
      tick();
      check("zero_later", rd_of(0), ZR ? 32'h0 : 32'hFFFFFFFF);

      // Hold on port 1 across writes to the held address
      bus.writeEnable = 1'b1; bus.writeAddress = 9; bus.writeData = 32'hA5A5A5A5;
      tick();
      bus.writeEnable = 1'b0; set_ra(1, 9);
      tick();
      check("hold_before", rd_of(1), 32'hA5A5A5A5);
      bus.readEnable[1] = 1'b0;
      bus.writeEnable = 1'b1; bus.writeData = 32'h5A5A5A5A;
      for (int i = 0; i < 4; i++) begin
         tick();
         check($sformatf("hold_cyc%0d", i), rd_of(1), 32'hA5A5A5A5);
      end
      bus.writeEnable = 1'b0; bus.readEnable[1] = 1'b1;
      tick();
      check("hold_release", rd_of(1), 32'h5A5A5A5A);

      // Reset mid-sweep with a dropped INIT write
      resetN = 1'b0;
      tick();
      resetN = 1'b1;
      repeat (9) tick();
      bus.writeEnable = 1'b1; bus.writeAddress = 3; bus.writeData = 32'h1234;
      tick();
      bus.writeEnable = 1'b0;
      resetN = 1'b0;
      #1;
      check("midreset_busy", DW'(bus.initBusy), DW'(1));
      check("midreset_rdata1", rd_of(1), '0);
      tick(); tick();
      resetN = 1'b1;
      wait_sweep("resweep_len");
      set_ra(0, 3);
      tick();
      check("init_write_dropped", rd_of(0), '0);

      // Randomised traffic on a narrow address range to provoke collisions
      repeat (3000) begin
         bus.writeEnable  = 1'($urandom_range(0, 1));
         bus.writeAddress = AW'($urandom_range(0, 7));
         bus.writeData    = $urandom;
         bus.readEnable   = RP'($urandom);
         for (int p = 0; p < RP; p++) set_ra(p, AW'($urandom_range(0, 7)));
         tick();
      end
      bus.writeEnable = 1'b0;
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
